seq_rotate_left: RTL

//  Multi-cycle inverse of the combinational rotate-right barrel stage: accepts a rotated

---
 rtl/seq_rotate_left_pkg.sv | 15 +
 rtl/seq_rotate_left_if.sv | 32 +++
 rtl/seq_rotate_left_rotl1.sv | 14 +
 rtl/seq_rotate_left.sv | 97 +++++++++
 4 files changed

// File: rtl/seq_rotate_left_pkg.sv
// Shared definitions for the sequential rotate-left block.
// Contents: FSM state encoding (IDLE/SHIFT/DONE) and default data geometry.
// The unused state code 2'd3 is not named; the FSM treats it as IDLE-bound.
package seq_rotate_left_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_SHW   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_rotate_left_if.sv
// Request/result bundle of the sequential rotate-left block.
// Signals:
//   start  request, sampled only while busy is low
//   W      rotated input word, captured with an accepted start
//   S      rotate-left amount, captured with an accepted start
//   Y      restored word, valid from the done pulse until the next accepted start
//   busy   high while an operation is in flight (SHIFT and DONE)
//   done   one-cycle pulse marking Y valid
// master = requester side, slave = rotate engine side.
interface seq_rotate_left_if #(
  parameter int WIDTH = seq_rotate_left_pkg::DEF_WIDTH,
  parameter int SHW   = seq_rotate_left_pkg::DEF_SHW
);

  logic             start;
  logic [WIDTH-1:0] W;
  logic [SHW-1:0]   S;
  logic [WIDTH-1:0] Y;
  logic             busy;
  logic             done;

  modport master (
    output start, W, S,
    input  Y, busy, done
  );

  modport slave (
    input  start, W, S,
    output Y, busy, done
  );

endinterface

// File: rtl/seq_rotate_left_rotl1.sv
// Single-bit rotate-left slice: the only rotate hardware in the block.
// Ports:
//   d  input word
//   q  d rotated left by one position (MSB wraps into LSB)
module seq_rotate_left_rotl1 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  assign q = {d[WIDTH-2:0], d[WIDTH-1]};

endmodule

// File: rtl/seq_rotate_left.sv
// Sequential rotate-left: undoes a rotate-right by rotating the captured word
// left one bit per clock, S times, then pulses done with the result on Y.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset (abandons any in-flight operation)
//   bus  seq_rotate_left_if slave: start/W/S in, Y/busy/done out
// busy and done are decoded from the state register only.
module seq_rotate_left
  import seq_rotate_left_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW
) (
  input  logic               clk,
  input  logic               rst,
  seq_rotate_left_if.slave   bus
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_rot;
  logic [SHW-1:0]   cnt;
  logic             busy;
  logic             done;

  seq_rotate_left_rotl1 #(.WIDTH(WIDTH)) u_rotl1 (
    .d (y),
    .q (y_rot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        // The zero count exits here, so the decrement below never wraps.
        if (cnt == '0) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: capture in IDLE, one rotate per SHIFT cycle while count remains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y   <= '0;
      cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            y   <= bus.W;
            cnt <= bus.S;
          end
        end
        ST_SHIFT: begin
          if (cnt != '0) begin
            y   <= y_rot;
            cnt <= cnt - SHW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.Y    = y;
  assign bus.busy = busy;
  assign bus.done = done;

endmodule
